// File: rtl/reg_8x64b_wr_arbiter_if.sv
// Signal bundle between the two write-request sources, the arbiter and the
// 8x64b register file write port.
interface reg_8x64b_wr_arbiter_if;
  logic        a_valid;
  logic [2:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  pending_mask;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, pending_mask
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, pending_mask
  );
endinterface

// File: rtl/reg_8x64b_wr_arbiter.sv
// Two-source write arbiter for an 8x64b register file: each source queues into
// a 2-entry FIFO, heads are granted round-robin and presented one per cycle.
module reg_8x64b_wr_arbiter (
  input  logic                   clk,
  input  logic                   rst,
  reg_8x64b_wr_arbiter_if.slave  bus
);
  localparam int NSRC = 2;

  logic [NSRC-1:0] src_valid;
  logic [2:0]      src_addr  [NSRC];
  logic [63:0]     src_data  [NSRC];
  logic [1:0]      fifo_cnt  [NSRC];
  logic [66:0]     fifo_head [NSRC];
  logic [7:0]      fifo_mask [NSRC];
  logic [NSRC-1:0] grant;
  logic [66:0]     grant_head;

  // last_grant: 0 = A, 1 = B
  logic        last_grant_q, last_grant_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;

  assign src_valid   = {bus.b_valid, bus.a_valid};
  assign src_addr[0] = bus.a_addr;
  assign src_addr[1] = bus.b_addr;
  assign src_data[0] = bus.a_data;
  assign src_data[1] = bus.b_data;

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_fifo
      logic [1:0]  cnt_q, cnt_d;
      logic        rd_ptr_q, rd_ptr_d;
      logic [66:0] mem_q [2];
      logic [66:0] mem_d [2];
      logic        push;
      logic        wr_ptr;
      logic [7:0]  mask;

      // Ready comes from the registered count only, so a full FIFO refuses
      // a push even on the cycle its head is popped.
      assign push   = src_valid[gi] && (cnt_q != 2'd2);
      assign wr_ptr = rd_ptr_q ^ cnt_q[0];

      always_comb begin
        mem_d = mem_q;
        if (push) begin
          mem_d[wr_ptr] = {src_addr[gi], src_data[gi]};
        end
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, grant[gi]};
        rd_ptr_d = rd_ptr_q ^ grant[gi];
      end

      always_comb begin
        mask = 8'h00;
        if (cnt_q != 2'd0) begin
          mask[mem_q[rd_ptr_q][66:64]] = 1'b1;
        end
        if (cnt_q == 2'd2) begin
          mask[mem_q[~rd_ptr_q][66:64]] = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q    <= 2'd0;
          rd_ptr_q <= 1'b0;
          for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
          end
        end else begin
          cnt_q    <= cnt_d;
          rd_ptr_q <= rd_ptr_d;
          for (int i = 0; i < 2; i++) begin
            mem_q[i] <= mem_d[i];
          end
        end
      end

      assign fifo_cnt[gi]  = cnt_q;
      assign fifo_head[gi] = mem_q[rd_ptr_q];
      assign fifo_mask[gi] = mask;
    end
  endgenerate

  // A wins when B is empty or B was granted last; otherwise B if it has data.
  always_comb begin
    grant = '0;
    if (fifo_cnt[0] != 2'd0 && (fifo_cnt[1] == 2'd0 || last_grant_q)) begin
      grant = 2'b01;
    end else if (fifo_cnt[1] != 2'd0) begin
      grant = 2'b10;
    end
  end

  assign grant_head = grant[1] ? fifo_head[1] : fifo_head[0];

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = |grant;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (|grant) begin
      last_grant_d = grant[1];
      wr_addr_d    = grant_head[66:64];
      wr_data_d    = grant_head[63:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 3'd0;
      wr_data_q    <= 64'd0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.a_ready      = (fifo_cnt[0] != 2'd2);
  assign bus.b_ready      = (fifo_cnt[1] != 2'd2);
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pending_mask = fifo_mask[0] | fifo_mask[1] |
                            (wr_en_q ? (8'h01 << wr_addr_q) : 8'h00);
endmodule

// File: tb/tb_reg_8x64b_wr_arbiter.sv
// Self-checking bench for reg_8x64b_wr_arbiter: directed scenarios plus random
// traffic compared against a queue-based model of the two sources.
module tb_reg_8x64b_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_8x64b_wr_arbiter_if bus();

  reg_8x64b_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  addr;
    logic [63:0] data;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model: per-source queues of at most two writes, the write
  // currently presented, and which source was granted most recently.
  ent_t        qa[$];
  ent_t        qb[$];
  bit          m_last_b;
  bit          exp_wr_en;
  logic [2:0]  exp_wr_addr;
  logic [63:0] exp_wr_data;
  bit          last_acc_a;
  bit          last_acc_b;
  int          acc_count;

  function automatic logic [7:0] model_pending();
    logic [7:0] m;
    m = 8'h00;
    foreach (qa[i]) m[qa[i].addr] = 1'b1;
    foreach (qb[i]) m[qb[i].addr] = 1'b1;
    if (exp_wr_en) m[exp_wr_addr] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    m_last_b    = 1'b1;
    exp_wr_en   = 1'b0;
    exp_wr_addr = 3'd0;
    exp_wr_data = 64'd0;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_addr  = 3'd0;
    bus.b_addr  = 3'd0;
    bus.a_data  = 64'd0;
    bus.b_data  = 64'd0;
  endtask

  // Advance one rising edge and update the model from the inputs seen there.
  task automatic step();
    int   pick;
    ent_t e;
    @(posedge clk);
    last_acc_a = bus.a_valid && (qa.size() < 2);
    last_acc_b = bus.b_valid && (qb.size() < 2);
    pick = 0;
    if (qa.size() > 0 && qb.size() > 0) pick = m_last_b ? 1 : 2;
    else if (qa.size() > 0) pick = 1;
    else if (qb.size() > 0) pick = 2;
    exp_wr_en = (pick != 0);
    if (pick == 1) begin
      e = qa.pop_front();
      m_last_b = 1'b0;
    end
    if (pick == 2) begin
      e = qb.pop_front();
      m_last_b = 1'b1;
    end
    if (pick != 0) begin
      exp_wr_addr = e.addr;
      exp_wr_data = e.data;
      $display("write src=%s addr=%0d data=%h", (pick == 1) ? "A" : "B", e.addr, e.data);
    end
    if (last_acc_a) begin
      qa.push_back({bus.a_addr, bus.a_data});
      acc_count++;
    end
    if (last_acc_b) begin
      qb.push_back({bus.b_addr, bus.b_data});
      acc_count++;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_clear();
    #2;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
    total++; if (bus.wr_addr !== 3'd0 || bus.wr_data !== 64'd0) begin bad++; $display("FAIL rst_wr_bus got=%0d/%h exp=0/0", bus.wr_addr, bus.wr_data); end
    total++; if (bus.pending_mask !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h exp=00", bus.pending_mask); end
    total++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b%b exp=11", bus.a_ready, bus.b_ready); end
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rst_clocked_wr_en got=%b exp=0", bus.wr_en); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.a_ready !== 1'b1 || bus.pending_mask !== 8'h00) begin bad++; $display("FAIL rst_release got=%b/%h exp=1/00", bus.a_ready, bus.pending_mask); end
  endtask

  task automatic test_single_write();
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd5;
    bus.a_data  = 64'hDEADBEEF_00000001;
    step();
    idle_inputs();
    total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h20) begin bad++; $display("FAIL single_e0 got=%b/%h exp=0/20", bus.wr_en, bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd5) begin bad++; $display("FAIL single_e1 got=%b/%0d exp=1/5", bus.wr_en, bus.wr_addr); end
    total++; if (bus.wr_data !== 64'hDEADBEEF_00000001) begin bad++; $display("FAIL single_data got=%h exp=deadbeef00000001", bus.wr_data); end
    total++; if (bus.pending_mask !== 8'h20) begin bad++; $display("FAIL single_pend_e1 got=%h exp=20", bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h00) begin bad++; $display("FAIL single_e2 got=%b/%h exp=0/00", bus.wr_en, bus.pending_mask); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 64'h0000_0000_0000_00A1;
    bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 64'h0000_0000_0000_00B2;
    step();
    idle_inputs();
    total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h06) begin bad++; $display("FAIL cont_e0 got=%b/%h exp=0/06", bus.wr_en, bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd1 || bus.wr_data !== 64'hA1) begin bad++; $display("FAIL cont_first got=%b/%0d/%h exp=1/1/a1", bus.wr_en, bus.wr_addr, bus.wr_data); end
    step();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd2 || bus.wr_data !== 64'hB2) begin bad++; $display("FAIL cont_second got=%b/%0d/%h exp=1/2/b2", bus.wr_en, bus.wr_addr, bus.wr_data); end
    total++; if (bus.pending_mask !== 8'h04) begin bad++; $display("FAIL cont_pend got=%h exp=04", bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL cont_idle got=%b exp=0", bus.wr_en); end
  endtask

  task automatic test_same_addr();
    bus.a_valid = 1'b1; bus.a_addr = 3'd7; bus.a_data = 64'h1;
    bus.b_valid = 1'b1; bus.b_addr = 3'd7; bus.b_data = 64'h2;
    step();
    idle_inputs();
    step();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd7 || bus.wr_data !== 64'h1) begin bad++; $display("FAIL same_first got=%b/%0d/%h exp=1/7/1", bus.wr_en, bus.wr_addr, bus.wr_data); end
    total++; if (bus.pending_mask !== 8'h80) begin bad++; $display("FAIL same_pend1 got=%h exp=80", bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd7 || bus.wr_data !== 64'h2) begin bad++; $display("FAIL same_second got=%b/%0d/%h exp=1/7/2", bus.wr_en, bus.wr_addr, bus.wr_data); end
    total++; if (bus.pending_mask !== 8'h80) begin bad++; $display("FAIL same_pend2 got=%h exp=80", bus.pending_mask); end
    step();
    total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h00) begin bad++; $display("FAIL same_done got=%b/%h exp=0/00", bus.wr_en, bus.pending_mask); end
  endtask

  task automatic test_backpressure();
    logic [63:0] b_items [3];
    logic [63:0] seen[$];
    int bi;
    bi = 0;
    for (int i = 0; i < 3; i++) b_items[i] = {8'hBB, 24'(i), $urandom};
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.a_valid = (cyc < 8);
      bus.a_addr  = 3'($urandom_range(0, 7));
      bus.a_data  = {8'hAA, 24'(cyc), $urandom};
      bus.b_valid = (bi < 3);
      bus.b_addr  = 3'(bi);
      bus.b_data  = b_items[(bi < 3) ? bi : 0];
      step();
      if (last_acc_b) bi++;
      total++; if (bus.wr_en !== exp_wr_en || bus.wr_addr !== exp_wr_addr || bus.wr_data !== exp_wr_data) begin bad++; $display("FAIL bp_wr cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.wr_en, bus.wr_addr, bus.wr_data, exp_wr_en, exp_wr_addr, exp_wr_data); end
      total++; if (bus.pending_mask !== model_pending()) begin bad++; $display("FAIL bp_pend cyc=%0d got=%h exp=%h", cyc, bus.pending_mask, model_pending()); end
      if (qb.size() == 2) begin
        total++; if (bus.b_ready !== 1'b0) begin bad++; $display("FAIL bp_b_ready_full cyc=%0d got=%b exp=0", cyc, bus.b_ready); end
      end
      if (bus.wr_en === 1'b1 && bus.wr_data[63:56] === 8'hBB) seen.push_back(bus.wr_data);
    end
    idle_inputs();
    total++; if (seen.size() != 3) begin bad++; $display("FAIL bp_b_count got=%0d exp=3", seen.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) begin
        total++; if (seen[i] !== b_items[i]) begin bad++; $display("FAIL bp_b_order idx=%0d got=%h exp=%h", i, seen[i], b_items[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    bit want_b;
    int n_wr;
    do_reset();
    want_b    = 1'b0;
    n_wr      = 0;
    acc_count = 0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      bus.a_valid = (cyc < 20);
      bus.a_addr  = 3'($urandom_range(0, 7));
      bus.a_data  = {8'hAA, 24'(cyc), $urandom};
      bus.b_valid = (cyc < 20);
      bus.b_addr  = 3'($urandom_range(0, 7));
      bus.b_data  = {8'hBB, 24'(cyc), $urandom};
      step();
      total++; if (bus.wr_en !== exp_wr_en || bus.wr_addr !== exp_wr_addr || bus.wr_data !== exp_wr_data) begin bad++; $display("FAIL sat_wr cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.wr_en, bus.wr_addr, bus.wr_data, exp_wr_en, exp_wr_addr, exp_wr_data); end
      if (cyc >= 1 && cyc < 20) begin
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL sat_busy cyc=%0d got=%b exp=1", cyc, bus.wr_en); end
        total++; if (bus.wr_data[63:56] !== (want_b ? 8'hBB : 8'hAA)) begin bad++; $display("FAIL sat_alternate cyc=%0d got=%h exp=%h", cyc, bus.wr_data[63:56], want_b ? 8'hBB : 8'hAA); end
        want_b = ~want_b;
      end
      if (bus.wr_en === 1'b1) n_wr++;
    end
    idle_inputs();
    total++; if (n_wr != acc_count) begin bad++; $display("FAIL sat_no_loss got=%0d exp=%0d", n_wr, acc_count); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      bus.a_valid = ($urandom_range(0, 99) < 55);
      bus.a_addr  = 3'($urandom_range(0, 7));
      bus.a_data  = {$urandom, $urandom};
      bus.b_valid = ($urandom_range(0, 99) < 45);
      bus.b_addr  = 3'($urandom_range(0, 7));
      bus.b_data  = {$urandom, $urandom};
      step();
      total++; if (bus.wr_en !== exp_wr_en || bus.wr_addr !== exp_wr_addr || bus.wr_data !== exp_wr_data) begin bad++; $display("FAIL rnd_wr cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.wr_en, bus.wr_addr, bus.wr_data, exp_wr_en, exp_wr_addr, exp_wr_data); end
      total++; if (bus.pending_mask !== model_pending()) begin bad++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", cyc, bus.pending_mask, model_pending()); end
      total++; if (bus.a_ready !== (qa.size() < 2) || bus.b_ready !== (qb.size() < 2)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", cyc, bus.a_ready, bus.b_ready, qa.size() < 2, qb.size() < 2); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    for (int cyc = 0; cyc < 2; cyc++) begin
      bus.a_valid = 1'b1; bus.a_addr = 3'(cyc + 3); bus.a_data = {8'hAA, 56'(cyc)};
      bus.b_valid = 1'b1; bus.b_addr = 3'(cyc + 5); bus.b_data = {8'hBB, 56'(cyc)};
      step();
    end
    idle_inputs();
    total++; if (bus.wr_en !== 1'b1 || bus.pending_mask === 8'h00) begin bad++; $display("FAIL mid_loaded got=%b/%h exp=1/nonzero", bus.wr_en, bus.pending_mask); end
    rst = 1'b0;
    model_clear();
    #1;
    total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h00) begin bad++; $display("FAIL mid_drop got=%b/%h exp=0/00", bus.wr_en, bus.pending_mask); end
    total++; if (bus.wr_addr !== 3'd0 || bus.wr_data !== 64'd0 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin bad++; $display("FAIL mid_regs got=%0d/%h/%b%b exp=0/0/11", bus.wr_addr, bus.wr_data, bus.a_ready, bus.b_ready); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      total++; if (bus.wr_en !== 1'b0 || bus.pending_mask !== 8'h00) begin bad++; $display("FAIL mid_after cyc=%0d got=%b/%h exp=0/00", cyc, bus.wr_en, bus.pending_mask); end
    end
  endtask

  initial begin
    acc_count = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
